phase_arbiter: RTL and testbench

Shares one phase-estimation unit (atan/CORDIC) between the two per-antenna short-preamble synchronizers in the antenna-diversity receive path. Each synchronizer's I/Q phase request is captured in a one-entry holding buffer. Requests are issued to the shared unit in round-robin order, and an in-order tag FIFO routes each returned phase back to the requester that asked for it. The block sits between the two sync_short instances and the single phase unit instantiated at the diversity level.

---
 rtl/phase_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_phase_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_arbiter.sv
// Purpose: round-robin sharing of one phase unit between two sync requesters, with tag-routed returns (optional PHASE_ARB_DROP_CNT_EN drop counters).
// Latency: 2 cycles req_stb -> phase_in_stb uncontended; 1 cycle phase_out_stb -> rsp_stb.
// Backpressure: issue stalls while the tag FIFO is full with no pop; a strobe into a held, ungranted buffer is dropped.

module phase_arb_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal only when a pop frees the slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module phase_arbiter #(
    parameter int TAG_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [31:0] req1_i,
    input  logic [31:0] req1_q,
    input  logic        req1_stb,
    input  logic [31:0] req2_i,
    input  logic [31:0] req2_q,
    input  logic        req2_stb,
    output logic [31:0] phase_in_i,
    output logic [31:0] phase_in_q,
    output logic        phase_in_stb,
    input  logic [31:0] phase_out,
    input  logic        phase_out_stb,
    output logic [31:0] rsp1_phase,
    output logic [31:0] rsp2_phase,
    output logic        rsp1_stb,
    output logic        rsp2_stb,
    output logic [1:0]  overflow,
    output logic        spurious,
    output logic        busy
`ifdef PHASE_ARB_DROP_CNT_EN
    ,
    output logic [15:0] drop_cnt1,
    output logic [15:0] drop_cnt2
`endif
);
    logic        buf1_vld;
    logic [31:0] buf1_i;
    logic [31:0] buf1_q;
    logic        buf2_vld;
    logic [31:0] buf2_i;
    logic [31:0] buf2_q;
    logic        last_grant;   // 0: requester 1 granted last, 1: requester 2

    logic        tag_empty;
    logic        tag_full;
    logic [0:0]  tag_head;
    logic        tag_pop;

    logic        can_issue;
    logic        grant1;
    logic        grant2;
    logic        load1;
    logic        load2;
    logic        accept1;
    logic        accept2;
    logic        drop1;
    logic        drop2;

    assign tag_pop = phase_out_stb && !tag_empty;

    always_comb begin
        can_issue = enable && (buf1_vld || buf2_vld) && (!tag_full || tag_pop);
        grant1    = can_issue && buf1_vld && (!buf2_vld || last_grant);
        grant2    = can_issue && buf2_vld && !grant1;
        load1     = enable && req1_stb;
        load2     = enable && req2_stb;
        // A buffer being granted this cycle frees up in time to take the new sample.
        accept1   = load1 && (!buf1_vld || grant1);
        accept2   = load2 && (!buf2_vld || grant2);
        drop1     = load1 && buf1_vld && !grant1;
        drop2     = load2 && buf2_vld && !grant2;
    end

    phase_arb_fifo #(
        .WIDTH (1),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (grant1 || grant2),
        .push_dat (grant2),
        .pop      (tag_pop),
        .pop_dat  (tag_head),
        .empty    (tag_empty),
        .full     (tag_full)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buf1_vld <= 1'b0;
            buf1_i   <= '0;
            buf1_q   <= '0;
            buf2_vld <= 1'b0;
            buf2_i   <= '0;
            buf2_q   <= '0;
            overflow <= '0;
        end else begin
            if (accept1) begin
                buf1_vld <= 1'b1;
                buf1_i   <= req1_i;
                buf1_q   <= req1_q;
            end else if (grant1) begin
                buf1_vld <= 1'b0;
            end
            if (accept2) begin
                buf2_vld <= 1'b1;
                buf2_i   <= req2_i;
                buf2_q   <= req2_q;
            end else if (grant2) begin
                buf2_vld <= 1'b0;
            end
            if (drop1) overflow[0] <= 1'b1;
            if (drop2) overflow[1] <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_in_stb <= 1'b0;
            phase_in_i   <= '0;
            phase_in_q   <= '0;
            last_grant   <= 1'b1;
        end else begin
            phase_in_stb <= grant1 || grant2;
            if (grant1) begin
                phase_in_i <= buf1_i;
                phase_in_q <= buf1_q;
                last_grant <= 1'b0;
            end else if (grant2) begin
                phase_in_i <= buf2_i;
                phase_in_q <= buf2_q;
                last_grant <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp1_stb   <= 1'b0;
            rsp2_stb   <= 1'b0;
            rsp1_phase <= '0;
            rsp2_phase <= '0;
            spurious   <= 1'b0;
        end else begin
            rsp1_stb <= tag_pop && !tag_head[0];
            rsp2_stb <= tag_pop &&  tag_head[0];
            if (tag_pop && !tag_head[0]) rsp1_phase <= phase_out;
            if (tag_pop &&  tag_head[0]) rsp2_phase <= phase_out;
            if (phase_out_stb && tag_empty) spurious <= 1'b1;
        end
    end

    assign busy = buf1_vld || buf2_vld || !tag_empty;

`ifdef PHASE_ARB_DROP_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt1 <= '0;
            drop_cnt2 <= '0;
        end else begin
            if (drop1 && (drop_cnt1 != 16'hFFFF)) drop_cnt1 <= drop_cnt1 + 16'd1;
            if (drop2 && (drop_cnt2 != 16'hFFFF)) drop_cnt2 <= drop_cnt2 + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_phase_arbiter.sv
// Directed bench for phase_arbiter: issue order, tag routing, overflow, tag-FIFO stall, spurious and async reset.
module tb_phase_arbiter;
    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable = 1'b1;
    logic [31:0] req1_i = '0;
    logic [31:0] req1_q = '0;
    logic        req1_stb = 1'b0;
    logic [31:0] req2_i = '0;
    logic [31:0] req2_q = '0;
    logic        req2_stb = 1'b0;
    logic [31:0] phase_in_i;
    logic [31:0] phase_in_q;
    logic        phase_in_stb;
    logic [31:0] phase_out = '0;
    logic        phase_out_stb = 1'b0;
    logic [31:0] rsp1_phase;
    logic [31:0] rsp2_phase;
    logic        rsp1_stb;
    logic        rsp2_stb;
    logic [1:0]  overflow;
    logic        spurious;
    logic        busy;
`ifdef PHASE_ARB_DROP_CNT_EN
    logic [15:0] drop_cnt1;
    logic [15:0] drop_cnt2;
`endif

    int tests = 0;
    int fails = 0;

    phase_arbiter #(.TAG_DEPTH(8)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .req1_i        (req1_i),
        .req1_q        (req1_q),
        .req1_stb      (req1_stb),
        .req2_i        (req2_i),
        .req2_q        (req2_q),
        .req2_stb      (req2_stb),
        .phase_in_i    (phase_in_i),
        .phase_in_q    (phase_in_q),
        .phase_in_stb  (phase_in_stb),
        .phase_out     (phase_out),
        .phase_out_stb (phase_out_stb),
        .rsp1_phase    (rsp1_phase),
        .rsp2_phase    (rsp2_phase),
        .rsp1_stb      (rsp1_stb),
        .rsp2_stb      (rsp2_stb),
        .overflow      (overflow),
        .spurious      (spurious),
        .busy          (busy)
`ifdef PHASE_ARB_DROP_CNT_EN
        ,
        .drop_cnt1     (drop_cnt1),
        .drop_cnt2     (drop_cnt2)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        req1_stb = 1'b0;
        req2_stb = 1'b0;
        phase_out_stb = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Expected phase_in_i sequence under full contention (requester 1 owns 0x1xx, requester 2 owns 0x2xx).
    logic [31:0] contend_exp [11] = '{32'h100, 32'h200, 32'h101, 32'h202, 32'h103, 32'h204,
                                      32'h105, 32'h206, 32'h107, 32'h208, 32'h109};

    initial begin
        // Reset state
        do_reset();
        check("rst_phase_in_stb", 32'(phase_in_stb), 32'd0);
        check("rst_phase_in_i", phase_in_i, 32'd0);
        check("rst_rsp1_stb", 32'(rsp1_stb), 32'd0);
        check("rst_rsp2_stb", 32'(rsp2_stb), 32'd0);
        check("rst_rsp1_phase", rsp1_phase, 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_spurious", 32'(spurious), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Single request, result returned a few cycles after issue
        req1_i = 32'h100; req1_q = 32'h200; req1_stb = 1'b1;
        tick();
        req1_stb = 1'b0;
        check("single_e0_stb", 32'(phase_in_stb), 32'd0);
        check("single_e0_busy", 32'(busy), 32'd1);
        tick();
        check("single_issue_stb", 32'(phase_in_stb), 32'd1);
        check("single_issue_i", phase_in_i, 32'h100);
        check("single_issue_q", phase_in_q, 32'h200);
        tick();
        check("single_stb_once", 32'(phase_in_stb), 32'd0);
        tick(); tick(); tick();
        phase_out = 32'h1234; phase_out_stb = 1'b1;
        tick();
        phase_out_stb = 1'b0;
        check("single_rsp1_stb", 32'(rsp1_stb), 32'd1);
        check("single_rsp1_phase", rsp1_phase, 32'h1234);
        check("single_rsp2_stb", 32'(rsp2_stb), 32'd0);
        tick();
        check("single_rsp1_once", 32'(rsp1_stb), 32'd0);
        check("single_idle_busy", 32'(busy), 32'd0);

        // Simultaneous requests after reset: requester 1 first
        do_reset();
        req1_i = 32'h11; req1_q = 32'h12; req1_stb = 1'b1;
        req2_i = 32'h22; req2_q = 32'h23; req2_stb = 1'b1;
        tick();
        req1_stb = 1'b0; req2_stb = 1'b0;
        check("sim_e0_stb", 32'(phase_in_stb), 32'd0);
        tick();
        check("sim_first_stb", 32'(phase_in_stb), 32'd1);
        check("sim_first_i", phase_in_i, 32'h11);
        check("sim_first_q", phase_in_q, 32'h12);
        tick();
        check("sim_second_stb", 32'(phase_in_stb), 32'd1);
        check("sim_second_i", phase_in_i, 32'h22);
        check("sim_second_q", phase_in_q, 32'h23);
        tick();
        check("sim_done_stb", 32'(phase_in_stb), 32'd0);
        phase_out = 32'hA1; phase_out_stb = 1'b1;
        tick();
        check("sim_rsp1_stb", 32'(rsp1_stb), 32'd1);
        check("sim_rsp1_phase", rsp1_phase, 32'hA1);
        check("sim_rsp1_no_rsp2", 32'(rsp2_stb), 32'd0);
        phase_out = 32'hB2;
        tick();
        phase_out_stb = 1'b0;
        check("sim_rsp2_stb", 32'(rsp2_stb), 32'd1);
        check("sim_rsp2_phase", rsp2_phase, 32'hB2);
        check("sim_rsp2_no_rsp1", 32'(rsp1_stb), 32'd0);
        tick();
        check("sim_busy", 32'(busy), 32'd0);
        check("sim_overflow", 32'(overflow), 32'd0);

        // Back-to-back strobes on requester 2, accepted during grant
        for (int k = 0; k < 4; k++) begin
            req2_stb = (k < 3);
            req2_i = 32'(k + 1);
            tick();
            if (k == 0) check("b2b_e0_stb", 32'(phase_in_stb), 32'd0);
            else begin
                check("b2b_issue_stb", 32'(phase_in_stb), 32'd1);
                check("b2b_issue_i", phase_in_i, 32'(k));
            end
        end
        tick();
        check("b2b_stb_end", 32'(phase_in_stb), 32'd0);
        check("b2b_overflow", 32'(overflow), 32'd0);
        for (int n = 0; n < 3; n++) begin
            phase_out = 32'hC0 + 32'(n); phase_out_stb = 1'b1;
            tick();
            check("b2b_rsp2_stb", 32'(rsp2_stb), 32'd1);
            check("b2b_rsp2_phase", rsp2_phase, 32'hC0 + 32'(n));
        end
        phase_out_stb = 1'b0;
        tick();
        check("b2b_busy", 32'(busy), 32'd0);

        // Full contention for 10 cycles with results returned every cycle
        for (int k = 0; k <= 12; k++) begin
            req1_stb = (k < 10); req1_i = 32'h100 + 32'(k);
            req2_stb = (k < 10); req2_i = 32'h200 + 32'(k);
            phase_out_stb = (k >= 2); phase_out = 32'h5000 + 32'(k);
            tick();
            if (k >= 1 && k <= 11) begin
                check("cont_issue_stb", 32'(phase_in_stb), 32'd1);
                check("cont_issue_i", phase_in_i, contend_exp[k-1]);
            end else begin
                check("cont_no_issue", 32'(phase_in_stb), 32'd0);
            end
            if (k >= 2) begin
                check("cont_rsp1_stb", 32'(rsp1_stb), 32'((k % 2) == 0));
                check("cont_rsp2_stb", 32'(rsp2_stb), 32'((k % 2) == 1));
            end
        end
        req1_stb = 1'b0; req2_stb = 1'b0; phase_out_stb = 1'b0;
        tick();
        check("cont_overflow", 32'(overflow), 32'd3);
        check("cont_busy", 32'(busy), 32'd0);
        check("cont_spurious", 32'(spurious), 32'd0);
`ifdef PHASE_ARB_DROP_CNT_EN
        check("cont_drop_cnt1", 32'(drop_cnt1), 32'd4);
        check("cont_drop_cnt2", 32'(drop_cnt2), 32'd5);
`endif

        // Tag FIFO fills after 8 outstanding issues, resumes on the pop edge
        for (int k = 0; k <= 10; k++) begin
            req1_stb = (k <= 8); req1_i = 32'h300 + 32'(k);
            tick();
            if (k >= 1 && k <= 8) begin
                check("full_issue_stb", 32'(phase_in_stb), 32'd1);
                check("full_issue_i", phase_in_i, 32'h300 + 32'(k - 1));
            end else if (k >= 9) begin
                check("full_stall_stb", 32'(phase_in_stb), 32'd0);
                check("full_stall_busy", 32'(busy), 32'd1);
            end
        end
        req1_stb = 1'b0;
        phase_out = 32'h7777; phase_out_stb = 1'b1;
        tick();
        check("full_resume_stb", 32'(phase_in_stb), 32'd1);
        check("full_resume_i", phase_in_i, 32'h308);
        check("full_pop_rsp1_stb", 32'(rsp1_stb), 32'd1);
        check("full_pop_rsp1_phase", rsp1_phase, 32'h7777);
        for (int n = 0; n < 8; n++) tick();
        phase_out_stb = 1'b0;
        tick();
        check("full_drain_busy", 32'(busy), 32'd0);
        check("full_drain_spurious", 32'(spurious), 32'd0);

        // Result with nothing outstanding
        phase_out = 32'hDEAD; phase_out_stb = 1'b1;
        tick();
        phase_out_stb = 1'b0;
        check("spur_flag", 32'(spurious), 32'd1);
        check("spur_rsp1_stb", 32'(rsp1_stb), 32'd0);
        check("spur_rsp2_stb", 32'(rsp2_stb), 32'd0);

        // Asynchronous reset in the middle of traffic
        req1_i = 32'h44; req1_stb = 1'b1;
        tick();
        req1_stb = 1'b0;
        tick();
        check("arst_pre_stb", 32'(phase_in_stb), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_phase_in_stb", 32'(phase_in_stb), 32'd0);
        check("arst_phase_in_i", phase_in_i, 32'd0);
        check("arst_rsp1_phase", rsp1_phase, 32'd0);
        check("arst_spurious", 32'(spurious), 32'd0);
        check("arst_overflow", 32'(overflow), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        phase_out = 32'h99; phase_out_stb = 1'b1;
        tick();
        phase_out_stb = 1'b0;
        check("post_rst_spurious", 32'(spurious), 32'd1);
        check("post_rst_rsp1_stb", 32'(rsp1_stb), 32'd0);

        // Enable low: strobes ignored, no issue, no overflow
        enable = 1'b0;
        req1_stb = 1'b1; req1_i = 32'h55;
        tick();
        tick();
        check("dis_busy", 32'(busy), 32'd0);
        check("dis_overflow", 32'(overflow), 32'd0);
        req1_stb = 1'b0; enable = 1'b1;
        tick();
        check("dis_no_issue", 32'(phase_in_stb), 32'd0);
        check("dis_busy_after", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
